// File: rtl/neuron_activation.sv
// neuron_activation: bias add, round/rescale, saturate and PLAN sigmoid for
// one neuron's accumulated dot product. Three-stage pipeline with
// valid/ready handshake on both sides. All stages advance together on adv.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset, clears all pipeline state
//   in_sum     signed accumulator value, 2*FRAC_BITS fraction bits
//   in_bias    signed bias, FRAC_BITS fraction bits
//   in_valid   in_sum/in_bias valid
//   in_ready   block accepts an input this cycle
//   act_sel    (NEURON_RELU_EN only) 1 = ReLU, 0 = sigmoid, travels with data
//   out_act    activation, unsigned, FRAC_BITS fraction bits
//   out_sat    pre-activation value was clamped
//   out_valid  out_act/out_sat valid
//   out_ready  consumer accepts this cycle
//
// Optional feature macro: NEURON_RELU_EN (adds act_sel and the ReLU path).

module neuron_activation #(
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [47:0] in_sum,
    input  logic signed [17:0] in_bias,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef NEURON_RELU_EN
    input  logic               act_sel,
`endif
    output logic [17:0]        out_act,
    output logic               out_sat,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned T_W   = 50;             // bias/round sum width
    localparam int unsigned Z_W   = T_W - FRAC_BITS; // rescaled width
    localparam int unsigned A_W   = 17;             // magnitude width
    localparam int unsigned ACT_W = 18;             // activation width

    localparam logic signed [T_W-1:0] RND    = T_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [Z_W-1:0] Z_HI   = Z_W'(131071);
    localparam logic signed [Z_W-1:0] Z_LO   = -Z_W'(131071);

    // PLAN breakpoints and offsets, expressed in units of 2^FRAC_BITS
    localparam logic [ACT_W-1:0] ONE  = ACT_W'(1)  << FRAC_BITS;        // 1.0
    localparam logic [ACT_W-1:0] BRK2 = ACT_W'(19) << (FRAC_BITS - 3);  // 2.375
    localparam logic [ACT_W-1:0] BRK3 = ACT_W'(5)  << FRAC_BITS;        // 5.0
    localparam logic [ACT_W-1:0] OFS1 = ACT_W'(1)  << (FRAC_BITS - 1);  // 0.5
    localparam logic [ACT_W-1:0] OFS2 = ACT_W'(5)  << (FRAC_BITS - 3);  // 0.625
    localparam logic [ACT_W-1:0] OFS3 = ACT_W'(27) << (FRAC_BITS - 5);  // 0.84375

    // Stage registers
    logic                  s1_valid_q, s1_valid_d;
    logic signed [Z_W-1:0] s1_z_q,     s1_z_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic [A_W-1:0]        s2_a_q,     s2_a_d;
    logic                  s2_sat_q,   s2_sat_d;
    logic                  s3_valid_q, s3_valid_d;
    logic [ACT_W-1:0]      s3_act_q,   s3_act_d;
    logic                  s3_sat_q,   s3_sat_d;
`ifdef NEURON_RELU_EN
    logic                  s1_sel_q,   s1_sel_d;
    logic                  s2_sel_q,   s2_sel_d;
`endif

    // Combinational datapath signals
    logic                  adv_c;
    logic signed [T_W-1:0] t_c;
    logic signed [A_W:0]   z_clamp_c;
    logic                  clamp_c;
    logic [ACT_W-1:0]      a_ext_c;
    logic [ACT_W-1:0]      y_c;
    logic [ACT_W-1:0]      act_c;

    // Whole pipeline moves together; bubbles are not collapsed
    assign adv_c    = !s3_valid_q || out_ready;
    assign in_ready = adv_c;

    // S1: add bias aligned to 2*FRAC_BITS, add half LSB, arithmetic shift
    assign t_c = T_W'(in_sum) + (T_W'(in_bias) <<< FRAC_BITS) + RND;

    // S2: symmetric clamp so the magnitude always fits in A_W bits
    always_comb begin
        clamp_c   = 1'b0;
        z_clamp_c = (A_W + 1)'(s1_z_q);
        if (s1_z_q > Z_HI) begin
            clamp_c   = 1'b1;
            z_clamp_c = (A_W + 1)'(Z_HI);
        end else if (s1_z_q < Z_LO) begin
            clamp_c   = 1'b1;
            z_clamp_c = (A_W + 1)'(Z_LO);
        end
    end

    // S3: piecewise-linear sigmoid on |z|, mirrored for negative z
    assign a_ext_c = ACT_W'(s2_a_q);

    always_comb begin
        y_c = ONE;
        if (a_ext_c < ONE) begin
            y_c = (a_ext_c >> 2) + OFS1;
        end else if (a_ext_c < BRK2) begin
            y_c = (a_ext_c >> 3) + OFS2;
        end else if (a_ext_c < BRK3) begin
            y_c = (a_ext_c >> 5) + OFS3;
        end
    end

    always_comb begin
        act_c = s2_sign_q ? (ONE - y_c) : y_c;
`ifdef NEURON_RELU_EN
        if (s2_sel_q) begin
            act_c = s2_sign_q ? '0 : a_ext_c;
        end
`endif
    end

    // Next-state: hold everything unless the pipeline advances
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_z_d     = s1_z_q;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_a_d     = s2_a_q;
        s2_sat_d   = s2_sat_q;
        s3_valid_d = s3_valid_q;
        s3_act_d   = s3_act_q;
        s3_sat_d   = s3_sat_q;
`ifdef NEURON_RELU_EN
        s1_sel_d   = s1_sel_q;
        s2_sel_d   = s2_sel_q;
`endif
        if (adv_c) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
            // Payload only loads behind a valid item; bubbles leave it alone
            if (in_valid) begin
                s1_z_d   = Z_W'(t_c >>> FRAC_BITS);
`ifdef NEURON_RELU_EN
                s1_sel_d = act_sel;
`endif
            end
            if (s1_valid_q) begin
                s2_sat_d  = clamp_c;
                s2_sign_d = z_clamp_c[A_W];
                s2_a_d    = z_clamp_c[A_W] ? A_W'(-z_clamp_c) : A_W'(z_clamp_c);
`ifdef NEURON_RELU_EN
                s2_sel_d  = s1_sel_q;
`endif
            end
            if (s2_valid_q) begin
                s3_act_d = act_c;
                s3_sat_d = s2_sat_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_z_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_a_q     <= '0;
            s2_sat_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_act_q   <= '0;
            s3_sat_q   <= 1'b0;
`ifdef NEURON_RELU_EN
            s1_sel_q   <= 1'b0;
            s2_sel_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_z_q     <= s1_z_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_a_q     <= s2_a_d;
            s2_sat_q   <= s2_sat_d;
            s3_valid_q <= s3_valid_d;
            s3_act_q   <= s3_act_d;
            s3_sat_q   <= s3_sat_d;
`ifdef NEURON_RELU_EN
            s1_sel_q   <= s1_sel_d;
            s2_sel_q   <= s2_sel_d;
`endif
        end
    end

    assign out_act   = s3_act_q;
    assign out_sat   = s3_sat_q;
    assign out_valid = s3_valid_q;

endmodule

// File: tb/tb_neuron_activation.sv
// Directed testbench for neuron_activation (FRAC_BITS = 12).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_neuron_activation;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [47:0] in_sum;
    logic signed [17:0] in_bias;
    logic               in_valid;
    logic               in_ready;
    logic [17:0]        out_act;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready;
`ifdef NEURON_RELU_EN
    logic               act_sel;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    neuron_activation #(.FRAC_BITS(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_sum    (in_sum),
        .in_bias   (in_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef NEURON_RELU_EN
        .act_sel   (act_sel),
`endif
        .out_act   (out_act),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Accumulator value whose rescaled integer is z (z * 2^12 in 2*FRAC units)
    function automatic logic signed [47:0] zs(input longint z);
        return 48'(z <<< 12);
    endfunction

    // Send one item with out_ready high; lat is -1 if no output within bound
    task automatic run_one(input logic signed [47:0] s, input logic signed [17:0] b,
                           output logic [17:0] act, output logic sat, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = s;
        in_bias   = b;
        @(negedge clk);
        in_valid  = 1'b0;
        lat       = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        act = out_act;
        sat = out_sat;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_bias   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
        end
        n_tests++;
        if (out_act !== 18'd0) begin
            n_fail++; $display("FAIL reset_out_act got=%0d want=0", out_act);
        end
        n_tests++;
        if (out_sat !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_sat got=%0b want=0", out_sat);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
        end
    endtask

    task automatic test_latency();
        logic [17:0] act;
        logic        sat;
        int          lat;
        run_one(48'sd0, 18'sd0, act, sat, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL latency got=%0d want=3", lat);
        end
        n_tests++;
        if (act !== 18'd2048) begin
            n_fail++; $display("FAIL zero_act got=%0d want=2048", act);
        end
        n_tests++;
        if (sat !== 1'b0) begin
            n_fail++; $display("FAIL zero_sat got=%0b want=0", sat);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_item_drain out_valid got=%0b want=0", out_valid);
        end
    endtask

    task automatic test_values();
        localparam int N = 21;
        logic signed [47:0] s  [N];
        logic signed [17:0] b  [N];
        logic [17:0]        ea [N];
        logic               es [N];
        logic [17:0]        act;
        logic               sat;
        int                 lat;
        s[0]  = zs(4096);    b[0]  = 18'sd0;     ea[0]  = 18'd3072; es[0]  = 1'b0;
        s[1]  = zs(-4096);   b[1]  = 18'sd0;     ea[1]  = 18'd1024; es[1]  = 1'b0;
        s[2]  = zs(-8192);   b[2]  = 18'sd0;     ea[2]  = 18'd512;  es[2]  = 1'b0;
        s[3]  = 48'sd0;      b[3]  = 18'sd4096;  ea[3]  = 18'd3072; es[3]  = 1'b0;
        s[4]  = 48'sd2048;   b[4]  = 18'sd0;     ea[4]  = 18'd2048; es[4]  = 1'b0;
        s[5]  = 48'sd14336;  b[5]  = 18'sd0;     ea[5]  = 18'd2049; es[5]  = 1'b0;
        s[6]  = 48'sd14335;  b[6]  = 18'sd0;     ea[6]  = 18'd2048; es[6]  = 1'b0;
        s[7]  = 48'sd0;      b[7]  = -18'sd4096; ea[7]  = 18'd1024; es[7]  = 1'b0;
        s[8]  = zs(4096);    b[8]  = -18'sd8192; ea[8]  = 18'd1024; es[8]  = 1'b0;
        s[9]  = zs(4095);    b[9]  = 18'sd0;     ea[9]  = 18'd3071; es[9]  = 1'b0;
        s[10] = zs(9727);    b[10] = 18'sd0;     ea[10] = 18'd3775; es[10] = 1'b0;
        s[11] = zs(9728);    b[11] = 18'sd0;     ea[11] = 18'd3760; es[11] = 1'b0;
        s[12] = zs(20479);   b[12] = 18'sd0;     ea[12] = 18'd4095; es[12] = 1'b0;
        s[13] = zs(20480);   b[13] = 18'sd0;     ea[13] = 18'd4096; es[13] = 1'b0;
        s[14] = zs(-9727);   b[14] = 18'sd0;     ea[14] = 18'd321;  es[14] = 1'b0;
        s[15] = zs(131071);  b[15] = 18'sd0;     ea[15] = 18'd4096; es[15] = 1'b0;
        s[16] = zs(131072);  b[16] = 18'sd0;     ea[16] = 18'd4096; es[16] = 1'b1;
        s[17] = zs(-131071); b[17] = 18'sd0;     ea[17] = 18'd0;    es[17] = 1'b0;
        s[18] = zs(-131072); b[18] = 18'sd0;     ea[18] = 18'd0;    es[18] = 1'b1;
        s[19] = 48'sh4000_0000_0000; b[19] = 18'sd0; ea[19] = 18'd4096; es[19] = 1'b1;
        s[20] = 48'shC000_0000_0000; b[20] = 18'sd0; ea[20] = 18'd0;    es[20] = 1'b1;
        for (int i = 0; i < N; i++) begin
            run_one(s[i], b[i], act, sat, lat);
            n_tests++;
            if (lat < 0) begin
                n_fail++; $display("FAIL value[%0d] timeout got=no_output want=output", i);
            end else begin
                if (act !== ea[i]) begin
                    n_fail++; $display("FAIL value[%0d] act got=%0d want=%0d", i, act, ea[i]);
                end
                n_tests++;
                if (sat !== es[i]) begin
                    n_fail++; $display("FAIL value[%0d] sat got=%0b want=%0b", i, sat, es[i]);
                end
            end
        end
    endtask

    // Six items streamed; consumer stalls on cycles 4..7
    task automatic test_back_to_back();
        logic signed [47:0] s  [6];
        logic [17:0]        ea [6];
        logic               es [6];
        logic [17:0]        hold;
        int                 tx;
        int                 rx;
        s[0] = zs(0);     ea[0] = 18'd2048; es[0] = 1'b0;
        s[1] = zs(4096);  ea[1] = 18'd3072; es[1] = 1'b0;
        s[2] = zs(-4096); ea[2] = 18'd1024; es[2] = 1'b0;
        s[3] = zs(12288); ea[3] = 18'd3840; es[3] = 1'b0;
        s[4] = 48'sh4000_0000_0000; ea[4] = 18'd4096; es[4] = 1'b1;
        s[5] = zs(-8192); ea[5] = 18'd512;  es[5] = 1'b0;
        tx   = 0;
        rx   = 0;
        hold = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            if (cyc == 4) hold = out_act;
            if (cyc >= 4 && cyc <= 7) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_c%0d ready/valid got=%0b/%0b want=0/1", cyc, in_ready, out_valid);
                end
                n_tests++;
                if (out_act !== hold) begin
                    n_fail++; $display("FAIL stall_hold_c%0d act got=%0d want=%0d", cyc, out_act, hold);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (rx >= 6) begin
                    n_fail++; $display("FAIL b2b_extra got=item%0d want=none", rx);
                end else if (out_act !== ea[rx] || out_sat !== es[rx]) begin
                    n_fail++;
                    $display("FAIL b2b_item%0d got=%0d/%0b want=%0d/%0b", rx, out_act, out_sat, ea[rx], es[rx]);
                end
                rx++;
            end
            in_valid = (tx < 6);
            in_bias  = 18'sd0;
            if (tx < 6) in_sum = s[tx];
            if (in_ready && tx < 6) tx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (rx !== 6) begin
            n_fail++; $display("FAIL b2b_count got=%0d want=6", rx);
        end
    endtask

    // Reset with three items in flight; none may be delivered
    task automatic test_reset_flight();
        logic [17:0] act;
        logic        sat;
        int          lat;
        int          leaks;
        @(negedge clk);
        out_ready = 1'b0;
        in_bias   = 18'sd0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum   = zs(4096 * (i + 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_out_valid got=%0b want=0", out_valid);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        leaks     = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) leaks++;
        end
        n_tests++;
        if (leaks !== 0) begin
            n_fail++; $display("FAIL flush_leak got=%0d want=0", leaks);
        end
        run_one(zs(4096), 18'sd0, act, sat, lat);
        n_tests++;
        if (lat !== 3 || act !== 18'd3072) begin
            n_fail++; $display("FAIL post_flush got=lat%0d/%0d want=lat3/3072", lat, act);
        end
    endtask

`ifdef NEURON_RELU_EN
    task automatic test_relu();
        logic signed [47:0] s  [4];
        logic               sl [4];
        logic [17:0]        ea [4];
        logic [17:0]        act;
        logic               sat;
        int                 lat;
        s[0] = zs(-4096); sl[0] = 1'b1; ea[0] = 18'd0;
        s[1] = zs(12288); sl[1] = 1'b1; ea[1] = 18'd12288;
        s[2] = zs(-4096); sl[2] = 1'b0; ea[2] = 18'd1024;
        s[3] = zs(12288); sl[3] = 1'b0; ea[3] = 18'd3840;
        for (int i = 0; i < 4; i++) begin
            act_sel = sl[i];
            run_one(s[i], 18'sd0, act, sat, lat);
            n_tests++;
            if (lat !== 3 || act !== ea[i]) begin
                n_fail++; $display("FAIL relu[%0d] got=lat%0d/%0d want=lat3/%0d", i, lat, act, ea[i]);
            end
        end
        act_sel = 1'b0;
    endtask
`endif

    initial begin
`ifdef NEURON_RELU_EN
        act_sel = 1'b0;
`endif
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_reset_flight();
`ifdef NEURON_RELU_EN
        test_relu();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
